upf_power_sequencer: RTL and testbench

UPF_POWER_SEQUENCER -- requirements
Module: upf_power_sequencer

---
 rtl/upf_power_sequencer.sv | 127 ++++++++++++
 tb/tb_upf_power_sequencer.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/upf_power_sequencer.sv
// Power-domain sequencer: clock-stop, isolate, retain, switch off, and the reverse on wake.
// Outputs are a Moore decode of the registered state; ERR is a sticky PWR_ACK-timeout flag.
module upf_power_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT   = 15
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       sleep_req_i,
  input  logic       wake_req_i,
  input  logic       pwr_ack_i,
  input  logic       err_clr_i,
  output logic       clk_en_o,
  output logic       iso_o,
  output logic       ret_o,
  output logic       pwr_o,
  output logic       sleep_ack_o,
  output logic       busy_o,
  output logic       err_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_RUN      = 4'd0,
    S_STOP_CLK = 4'd1,
    S_ISOLATE  = 4'd2,
    S_SAVE     = 4'd3,
    S_PD       = 4'd4,
    S_OFF      = 4'd5,
    S_PU       = 4'd6,
    S_RESTORE  = 4'd7,
    S_DEISO    = 4'd8
  } state_e;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] ACK_LAST    = 8'(ACK_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;
  logic       timeout_set;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_RUN;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timeout_set = 1'b0;
    clk_en_o    = 1'b0;
    iso_o       = 1'b1;
    ret_o       = 1'b0;
    pwr_o       = 1'b1;
    busy_o      = 1'b1;
    sleep_ack_o = 1'b0;
    case (state_q)
      S_RUN: begin
        clk_en_o = 1'b1;
        iso_o    = 1'b0;
        busy_o   = 1'b0;
        // Wake wins when both requests are high.
        if (sleep_req_i && !wake_req_i) state_d = S_STOP_CLK;
      end
      S_STOP_CLK: begin
        iso_o   = 1'b0;
        state_d = S_ISOLATE;
      end
      S_ISOLATE: state_d = S_SAVE;
      S_SAVE: begin
        ret_o = 1'b1;
        if (cnt_q == SETTLE_LAST) state_d = S_PD;
      end
      S_PD: begin
        ret_o = 1'b1;
        pwr_o = 1'b0;
        if (!pwr_ack_i) begin
          state_d = S_OFF;
        end else if (cnt_q == ACK_LAST) begin
          state_d     = S_OFF;
          timeout_set = 1'b1;
        end
      end
      S_OFF: begin
        ret_o       = 1'b1;
        pwr_o       = 1'b0;
        busy_o      = 1'b0;
        sleep_ack_o = 1'b1;
        if (wake_req_i) state_d = S_PU;
      end
      S_PU: begin
        ret_o = 1'b1;
        if (pwr_ack_i) begin
          state_d = S_RESTORE;
        end else if (cnt_q == ACK_LAST) begin
          state_d     = S_OFF;
          timeout_set = 1'b1;
        end
      end
      S_RESTORE: state_d = S_DEISO;
      S_DEISO: begin
        iso_o   = 1'b0;
        state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  // Counter restarts on each state entry and saturates instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)  cnt_d = 8'd0;
    else if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  assign err_d   = timeout_set | (err_q & ~err_clr_i);
  assign err_o   = err_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_upf_power_sequencer.sv
// Directed bench for upf_power_sequencer with a PWR_ACK model and a retention-register model.
module tb_upf_power_sequencer;

  logic       clk = 1'b0;
  logic       reset_i, sleep_req_i, wake_req_i, err_clr_i;
  logic       pwr_ack_i;
  logic       clk_en_o, iso_o, ret_o, pwr_o, sleep_ack_o, busy_o, err_o;
  logic [3:0] state_o;

  // ack_follow=1: PWR_ACK mirrors PWR; otherwise it is forced to ack_force.
  logic       ack_follow = 1'b1;
  logic       ack_force  = 1'b0;
  assign pwr_ack_i = ack_follow ? pwr_o : ack_force;

  int n_chk  = 0;
  int n_pass = 0;

  upf_power_sequencer #(.SETTLE_CYCLES(4), .ACK_TIMEOUT(15)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .sleep_req_i (sleep_req_i),
    .wake_req_i  (wake_req_i),
    .pwr_ack_i   (pwr_ack_i),
    .err_clr_i   (err_clr_i),
    .clk_en_o    (clk_en_o),
    .iso_o       (iso_o),
    .ret_o       (ret_o),
    .pwr_o       (pwr_o),
    .sleep_ack_o (sleep_ack_o),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  // Domain register: lost while unpowered, saved on RET rise, restored on RET fall.
  logic       dom_load = 1'b0;
  logic       prev_ret = 1'b0;
  logic [7:0] dom_q    = 8'h00;
  logic [7:0] save_q   = 8'h00;
  always @(posedge clk) begin
    prev_ret <= ret_o;
    if (dom_load)                dom_q <= 8'h5A;
    else if (!pwr_o)             dom_q <= 8'h00;
    else if (prev_ret && !ret_o) dom_q <= save_q;
    if (ret_o && !prev_ret) save_q <= dom_q;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // {CLK_EN, ISO, RET, PWR}
  function automatic logic [3:0] outs();
    return {clk_en_o, iso_o, ret_o, pwr_o};
  endfunction

  int         sl_state [8] = '{1, 2, 3, 3, 3, 3, 4, 5};
  logic [3:0] sl_outs  [8] = '{4'b0001, 4'b0101, 4'b0111, 4'b0111,
                               4'b0111, 4'b0111, 4'b0110, 4'b0110};
  int         wk_state [4] = '{6, 7, 8, 0};
  logic [3:0] wk_outs  [4] = '{4'b0111, 4'b0101, 4'b0001, 4'b1001};

  initial begin
    reset_i = 1'b1; sleep_req_i = 1'b1; wake_req_i = 1'b0; err_clr_i = 1'b0;
    tick();
    tick();
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_outs", 32'(outs()), 32'(4'b1001));
    check("rst_flags", 32'({sleep_ack_o, busy_o, err_o}), 32'd0);
    reset_i = 1'b0; sleep_req_i = 1'b0;

    // Both requests high: wake priority keeps RUN.
    sleep_req_i = 1'b1; wake_req_i = 1'b1; dom_load = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      dom_load = 1'b0;
      check("both_req", 32'({busy_o, state_o}), 32'd0);
    end

    // Nominal sleep with PWR_ACK tracking PWR.
    wake_req_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check($sformatf("sleep_state%0d", k + 1), 32'(state_o), 32'(sl_state[k]));
      check($sformatf("sleep_outs%0d", k + 1), 32'(outs()), 32'(sl_outs[k]));
      check($sformatf("sleep_ack%0d", k + 1), 32'({sleep_ack_o, busy_o}),
            (k == 7) ? 32'b10 : 32'b01);
    end
    tick();
    check("off_ignores_sleep", 32'(state_o), 32'd5);
    sleep_req_i = 1'b0;

    // Nominal wake and retention restore.
    wake_req_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("wake_state%0d", k + 1), 32'(state_o), 32'(wk_state[k]));
      check($sformatf("wake_outs%0d", k + 1), 32'(outs()), 32'(wk_outs[k]));
    end
    wake_req_i = 1'b0;
    check("retained", 32'(dom_q), 32'h5A);

    // PD timeout: PWR_ACK stuck high.
    ack_follow = 1'b0; ack_force = 1'b1; sleep_req_i = 1'b1;
    repeat (7) tick();
    check("pd_entry", 32'(state_o), 32'd4);
    sleep_req_i = 1'b0;
    repeat (14) tick();
    check("pd_wait", 32'({err_o, state_o}), 32'h04);
    tick();
    check("pd_timeout", 32'({err_o, state_o}), 32'h15);
    ack_follow = 1'b1; wake_req_i = 1'b1;
    repeat (4) tick();
    wake_req_i = 1'b0;
    check("err_sticky_wake", 32'({err_o, state_o}), 32'h10);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("err_clr", 32'(err_o), 32'd0);

    // PU timeout, with ERR_CLR coinciding with the timeout edge.
    sleep_req_i = 1'b1;
    repeat (8) tick();
    sleep_req_i = 1'b0;
    check("down_again", 32'(state_o), 32'd5);
    ack_follow = 1'b0; ack_force = 1'b0; wake_req_i = 1'b1;
    tick();
    wake_req_i = 1'b0;
    check("pu_entry", 32'(state_o), 32'd6);
    repeat (14) tick();
    check("pu_wait", 32'({err_o, state_o}), 32'h06);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("pu_timeout_set_wins", 32'({err_o, state_o}), 32'h15);
    tick();
    check("pu_err_hold", 32'({err_o, state_o}), 32'h15);
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    check("pu_err_clr", 32'(err_o), 32'd0);
    ack_follow = 1'b1; wake_req_i = 1'b1;
    repeat (4) tick();
    wake_req_i = 1'b0;
    check("back_to_run", 32'(state_o), 32'd0);

    // Wake raised in ISOLATE: power-down still completes, then straight to PU.
    sleep_req_i = 1'b1;
    tick();
    tick();
    check("wdp_isolate", 32'(state_o), 32'd2);
    sleep_req_i = 1'b0; wake_req_i = 1'b1;
    tick();
    check("wdp_save", 32'(state_o), 32'd3);
    repeat (5) tick();
    check("wdp_off", 32'(state_o), 32'd5);
    tick();
    check("wdp_pu", 32'(state_o), 32'd6);
    repeat (3) tick();
    check("wdp_run", 32'(state_o), 32'd0);
    wake_req_i = 1'b0;

    // Reset in SAVE.
    sleep_req_i = 1'b1;
    repeat (3) tick();
    check("mid_save", 32'(state_o), 32'd3);
    reset_i = 1'b1;
    tick();
    check("mid_rst_state", 32'({busy_o, state_o}), 32'd0);
    check("mid_rst_outs", 32'(outs()), 32'(4'b1001));
    reset_i = 1'b0; sleep_req_i = 1'b0;
    tick();
    check("post_rst_run", 32'(state_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
